// File: rtl/pc_pkg.sv
// Shared types and constants for the PC / fetch-sequencing stage.
package pc_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned PC_STEP     = 4;
  localparam int unsigned BR_OFFSET_W = 16;
  localparam int unsigned J_TARGET_W  = 26;

  localparam logic [PC_W-1:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned     IMEM_WORDS = 30;
  localparam logic [PC_W-1:0] EXIT_ADDR  = 32'h0000_007C;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

  // First byte address past the end of instruction memory.
  function automatic logic [PC_W-1:0] imem_limit();
    return PC_W'(IMEM_WORDS * PC_STEP);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: decoded control/fields in, PC and status out.
interface pc_fetch_if;
  import pc_pkg::*;

  logic                   stall;
  logic                   Branch;
  logic                   Zero;
  logic                   Jump;
  logic [J_TARGET_W-1:0]  I250;
  logic [BR_OFFSET_W-1:0] I150;
  logic [PC_W-1:0]        Raddr;
  logic [PC_W-1:0]        pc_plus4;
  logic                   halted;
  logic [PC_W-1:0]        retired;
  logic                   bound_err;

  modport master (
    output stall, Branch, Zero, Jump, I250, I150,
    input  Raddr, pc_plus4, halted, retired, bound_err
  );

  modport slave (
    input  stall, Branch, Zero, Jump, I250, I150,
    output Raddr, pc_plus4, halted, retired, bound_err
  );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC select: jump target, taken branch, or sequential.
module pc_next_calc
  import pc_pkg::*;
(
  input  logic [PC_W-1:0]        raddr,
  input  logic                   branch,
  input  logic                   zero,
  input  logic                   jump,
  input  logic [J_TARGET_W-1:0]  i250,
  input  logic [BR_OFFSET_W-1:0] i150,
  output logic [PC_W-1:0]        next_pc,
  output logic [PC_W-1:0]        pc_plus4
);

  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] j_target;

  always_comb begin
    pc_plus4  = raddr + PC_W'(PC_STEP);
    // Word-granular signed offset scaled to bytes.
    br_off    = {{(PC_W-BR_OFFSET_W-2){i150[BR_OFFSET_W-1]}}, i150, 2'b00};
    br_target = pc_plus4 + br_off;
    j_target  = {pc_plus4[PC_W-1:PC_W-4], i250, 2'b00};

    next_pc = pc_plus4;
    if (jump) begin
      next_pc = j_target;
    end else if (branch && zero) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Registered PC, fetch sequencing, exit-address halt and retire counter.
// Optional out-of-range fetch trap enabled by defining PC_BOUND_CHECK_EN.
module pc_fetch
  import pc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  pc_fetch_if.slave  bus
);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] retired_q, retired_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] pc_plus4;

  pc_next_calc u_next (
    .raddr    (pc_q),
    .branch   (bus.Branch),
    .zero     (bus.Zero),
    .jump     (bus.Jump),
    .i250     (bus.I250),
    .i150     (bus.I150),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

`ifdef PC_BOUND_CHECK_EN
  logic bound_err_q, bound_err_d;
  logic out_of_range;

  assign out_of_range = (next_pc >= imem_limit());
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    halted_d  = halted_q;
`ifdef PC_BOUND_CHECK_EN
    bound_err_d = bound_err_q;
`endif

    case (state_q)
      RUN: begin
        if (!bus.stall) begin
          if (next_pc == EXIT_ADDR) begin
            pc_d      = next_pc;
            retired_d = retired_q + PC_W'(1);
            halted_d  = 1'b1;
            state_d   = HALT;
`ifdef PC_BOUND_CHECK_EN
          end else if (out_of_range) begin
            // Trap before loading a PC that would fetch outside memory.
            bound_err_d = 1'b1;
            halted_d    = 1'b1;
            state_d     = FAULT;
`endif
          end else begin
            pc_d      = next_pc;
            retired_d = retired_q + PC_W'(1);
          end
        end
      end
      HALT, FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      halted_q  <= 1'b0;
`ifdef PC_BOUND_CHECK_EN
      bound_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
`ifdef PC_BOUND_CHECK_EN
      bound_err_q <= bound_err_d;
`endif
    end
  end

  assign bus.Raddr    = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.retired  = retired_q;
  assign bus.halted   = halted_q;
`ifdef PC_BOUND_CHECK_EN
  assign bus.bound_err = bound_err_q;
`else
  assign bus.bound_err = 1'b0;
`endif

endmodule
